// File: rtl/scr1_ahb_mem_arb.sv
// Two-master AHB-Lite arbiter: imem and dmem share one memory slave with zero-latency grant.
// Define SCR1_AHB_ARB_RR_EN for round-robin; otherwise dmem has priority with an imem starvation limit.

module scr1_ahb_mem_arb #(
    parameter int unsigned IMEM_STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  imem_htrans,
    input  logic [31:0] imem_haddr,
    input  logic [2:0]  imem_hsize,
    input  logic [3:0]  imem_hprot,
    output logic        imem_hready,
    output logic [31:0] imem_hrdata,
    output logic        imem_hresp,
    input  logic [1:0]  dmem_htrans,
    input  logic [31:0] dmem_haddr,
    input  logic [2:0]  dmem_hsize,
    input  logic [3:0]  dmem_hprot,
    input  logic        dmem_hwrite,
    input  logic [31:0] dmem_hwdata,
    output logic        dmem_hready,
    output logic [31:0] dmem_hrdata,
    output logic        dmem_hresp,
    output logic [1:0]  mem_htrans,
    output logic [31:0] mem_haddr,
    output logic [2:0]  mem_hsize,
    output logic [3:0]  mem_hprot,
    output logic        mem_hwrite,
    output logic [31:0] mem_hwdata,
    input  logic        mem_hready,
    input  logic [31:0] mem_hrdata,
    input  logic        mem_hresp
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IMEM = 2'b01,
        OWN_DMEM = 2'b10
    } own_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    own_e        dp_own_r;
    own_e        dp_own_nxt_s;

    logic        pend_imem_vld_r;
    logic        pend_imem_vld_nxt_s;
    logic [31:0] pend_imem_addr_r;
    logic [2:0]  pend_imem_size_r;
    logic [3:0]  pend_imem_prot_r;

    logic        pend_dmem_vld_r;
    logic        pend_dmem_vld_nxt_s;
    logic [31:0] pend_dmem_addr_r;
    logic [2:0]  pend_dmem_size_r;
    logic [3:0]  pend_dmem_prot_r;
    logic        pend_dmem_write_r;

    logic        imem_new_s;
    logic        dmem_new_s;
    logic        imem_req_s;
    logic        dmem_req_s;
    logic        arb_en_s;
    logic        grant_imem_s;
    logic        grant_dmem_s;
    logic        cap_imem_s;
    logic        cap_dmem_s;
    logic        unused_s;

`ifdef SCR1_AHB_ARB_RR_EN
    own_e        last_grant_r;
    own_e        last_grant_nxt_s;
    logic [3:0]  unused_starve_max_s;

    assign unused_starve_max_s = 4'(IMEM_STARVE_MAX);
`else
    localparam logic [3:0] STARVE_MAX_C = 4'(IMEM_STARVE_MAX);

    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_nxt_s;
`endif

    // htrans[0] only distinguishes SEQ from NONSEQ, and both are forwarded as NONSEQ.
    assign unused_s = imem_htrans[0] ^ dmem_htrans[0];

    // A master is stalled while its request waits in the pending slot; otherwise it follows
    // the slave only during its own data phase.
    assign imem_hready = pend_imem_vld_r ? 1'b0 : ((dp_own_r == OWN_IMEM) ? mem_hready : 1'b1);
    assign dmem_hready = pend_dmem_vld_r ? 1'b0 : ((dp_own_r == OWN_DMEM) ? mem_hready : 1'b1);
    assign imem_hresp  = (dp_own_r == OWN_IMEM) ? mem_hresp : 1'b0;
    assign dmem_hresp  = (dp_own_r == OWN_DMEM) ? mem_hresp : 1'b0;
    assign imem_hrdata = mem_hrdata;
    assign dmem_hrdata = mem_hrdata;
    assign mem_hwdata  = (dp_own_r == OWN_DMEM) ? dmem_hwdata : 32'h0000_0000;

    assign imem_new_s = imem_htrans[1] & imem_hready;
    assign dmem_new_s = dmem_htrans[1] & dmem_hready;
    assign imem_req_s = imem_new_s | pend_imem_vld_r;
    assign dmem_req_s = dmem_new_s | pend_dmem_vld_r;
    // Reset also blocks grants so the slave sees IDLE while rst_n is low.
    assign arb_en_s   = mem_hready & rst_n;

    // Arbitration: pick at most one winner among requesting masters.
    always_comb begin
        grant_imem_s = 1'b0;
        grant_dmem_s = 1'b0;
        if (arb_en_s) begin
            if (imem_req_s && dmem_req_s) begin
`ifdef SCR1_AHB_ARB_RR_EN
                if (last_grant_r == OWN_DMEM) begin
                    grant_imem_s = 1'b1;
                end else begin
                    grant_dmem_s = 1'b1;
                end
`else
                if (starve_cnt_r == STARVE_MAX_C) begin
                    grant_imem_s = 1'b1;
                end else begin
                    grant_dmem_s = 1'b1;
                end
`endif
            end else if (imem_req_s) begin
                grant_imem_s = 1'b1;
            end else if (dmem_req_s) begin
                grant_dmem_s = 1'b1;
            end else begin
                grant_imem_s = 1'b0;
                grant_dmem_s = 1'b0;
            end
        end else begin
            grant_imem_s = 1'b0;
            grant_dmem_s = 1'b0;
        end
    end

    // Shared slave address phase driven from the winner's pending slot or live bus.
    always_comb begin
        mem_htrans = HTRANS_IDLE;
        mem_haddr  = 32'h0000_0000;
        mem_hsize  = 3'b000;
        mem_hprot  = 4'b0000;
        mem_hwrite = 1'b0;
        if (grant_imem_s) begin
            mem_htrans = HTRANS_NONSEQ;
            mem_haddr  = pend_imem_vld_r ? pend_imem_addr_r : imem_haddr;
            mem_hsize  = pend_imem_vld_r ? pend_imem_size_r : imem_hsize;
            mem_hprot  = pend_imem_vld_r ? pend_imem_prot_r : imem_hprot;
            mem_hwrite = 1'b0;
        end else if (grant_dmem_s) begin
            mem_htrans = HTRANS_NONSEQ;
            mem_haddr  = pend_dmem_vld_r ? pend_dmem_addr_r  : dmem_haddr;
            mem_hsize  = pend_dmem_vld_r ? pend_dmem_size_r  : dmem_hsize;
            mem_hprot  = pend_dmem_vld_r ? pend_dmem_prot_r  : dmem_hprot;
            mem_hwrite = pend_dmem_vld_r ? pend_dmem_write_r : dmem_hwrite;
        end else begin
            mem_htrans = HTRANS_IDLE;
        end
    end

    assign cap_imem_s = imem_new_s & ~grant_imem_s;
    assign cap_dmem_s = dmem_new_s & ~grant_dmem_s;

    // Next state for pending slots, data-phase owner and fairness state.
    always_comb begin
        pend_imem_vld_nxt_s = pend_imem_vld_r;
        pend_dmem_vld_nxt_s = pend_dmem_vld_r;
        dp_own_nxt_s        = dp_own_r;

        if (grant_imem_s) begin
            pend_imem_vld_nxt_s = 1'b0;
        end else if (cap_imem_s) begin
            pend_imem_vld_nxt_s = 1'b1;
        end else begin
            pend_imem_vld_nxt_s = pend_imem_vld_r;
        end

        if (grant_dmem_s) begin
            pend_dmem_vld_nxt_s = 1'b0;
        end else if (cap_dmem_s) begin
            pend_dmem_vld_nxt_s = 1'b1;
        end else begin
            pend_dmem_vld_nxt_s = pend_dmem_vld_r;
        end

        if (mem_hready) begin
            case ({grant_dmem_s, grant_imem_s})
                2'b01:   dp_own_nxt_s = OWN_IMEM;
                2'b10:   dp_own_nxt_s = OWN_DMEM;
                default: dp_own_nxt_s = OWN_NONE;
            endcase
        end else begin
            dp_own_nxt_s = dp_own_r;
        end

`ifdef SCR1_AHB_ARB_RR_EN
        last_grant_nxt_s = last_grant_r;
        if (grant_imem_s) begin
            last_grant_nxt_s = OWN_IMEM;
        end else if (grant_dmem_s) begin
            last_grant_nxt_s = OWN_DMEM;
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
`else
        starve_cnt_nxt_s = starve_cnt_r;
        if (!imem_req_s || grant_imem_s) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (grant_dmem_s && (starve_cnt_r < STARVE_MAX_C)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
`endif
    end

    // State registers; reset discards any pending or in-flight transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_own_r          <= OWN_NONE;
            pend_imem_vld_r   <= 1'b0;
            pend_imem_addr_r  <= 32'h0000_0000;
            pend_imem_size_r  <= 3'b000;
            pend_imem_prot_r  <= 4'b0000;
            pend_dmem_vld_r   <= 1'b0;
            pend_dmem_addr_r  <= 32'h0000_0000;
            pend_dmem_size_r  <= 3'b000;
            pend_dmem_prot_r  <= 4'b0000;
            pend_dmem_write_r <= 1'b0;
`ifdef SCR1_AHB_ARB_RR_EN
            last_grant_r      <= OWN_IMEM;
`else
            starve_cnt_r      <= 4'd0;
`endif
        end else begin
            dp_own_r        <= dp_own_nxt_s;
            pend_imem_vld_r <= pend_imem_vld_nxt_s;
            pend_dmem_vld_r <= pend_dmem_vld_nxt_s;
            if (cap_imem_s) begin
                pend_imem_addr_r <= imem_haddr;
                pend_imem_size_r <= imem_hsize;
                pend_imem_prot_r <= imem_hprot;
            end
            if (cap_dmem_s) begin
                pend_dmem_addr_r  <= dmem_haddr;
                pend_dmem_size_r  <= dmem_hsize;
                pend_dmem_prot_r  <= dmem_hprot;
                pend_dmem_write_r <= dmem_hwrite;
            end
`ifdef SCR1_AHB_ARB_RR_EN
            last_grant_r <= last_grant_nxt_s;
`else
            starve_cnt_r <= starve_cnt_nxt_s;
`endif
        end
    end

endmodule
